clkmon: RTL

- Monitors a slow square-wave clock, e.g. the output of the team's even-ratio clock divider or an externally sourced LED/pixel clock, using the fast system clock.
- Measures each period of the monitored clock in system-clock cycles and reports lock once the period repeatedly matches the expected ratio.
- Flags loss of lock and a stalled input.
- Acts as the checking end of the divider: the divider generates a ratio, this block verifies it, at bring-up and continuously in the lamp FPGA.

---
 rtl/clkmon_sync_edge.sv | 28 ++
 rtl/clkmon.sv | 131 +++++++++++++
 2 files changed

// File: rtl/clkmon_sync_edge.sv
// Two-flop synchroniser plus a third flop for rising-edge detect on an asynchronous input.
// o_rise is a one-cycle pulse in the i_clk domain for each rising edge of i_async.
module sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise
);

    logic r_s1_p0;
    logic r_s2_p1;
    logic r_s3_p2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_p0 <= 1'b0;
            r_s2_p1 <= 1'b0;
            r_s3_p2 <= 1'b0;
        end else begin
            r_s1_p0 <= i_async;
            r_s2_p1 <= r_s1_p0;
            r_s3_p2 <= r_s2_p1;
        end
    end

    assign o_rise = r_s2_p1 & ~r_s3_p2;

endmodule

// File: rtl/clkmon.sv
// Measures the period of a slow clock in i_clk cycles, tracks lock against c_div,
// and flags loss of lock and a stalled input.
module clkmon #(
    parameter  int c_div      = 4,
    parameter  int c_tol      = 1,
    parameter  int c_lock_cnt = 4,
    localparam int W          = $clog2(2 * c_div + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_sclk,
    output logic [W-1:0] o_period,
    output logic         o_period_valid,
    output logic         o_locked,
    output logic         o_err,
    output logic         o_stall
);

    localparam int c_max = 2 * c_div;
    localparam int GW    = $clog2(c_lock_cnt + 1);
    localparam logic [GW-1:0] LOCK_G = GW'(c_lock_cnt);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t          r_state, state_nxt;
    logic [W-1:0]    r_count, count_nxt, m;
    logic [GW-1:0]   r_good, good_nxt;
    logic            e, sat;
    logic [W-1:0]    period_nxt;
    logic            valid_nxt, locked_nxt, err_nxt, stall_nxt;

    function automatic logic is_good(input logic [W-1:0] p);
        int d;
        d = int'(p) - c_div;
        return (d <= c_tol) && (d >= -c_tol);
    endfunction

    sync_edge u_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_async(i_sclk),
        .o_rise (e)
    );

    assign m   = r_count + W'(1);
    // Saturation is the cycle the counter would step onto c_max; an edge in that cycle wins.
    assign sat = !e && (r_count == W'(c_max - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_count        <= '0;
            r_good         <= '0;
            o_period       <= '0;
            o_period_valid <= 1'b0;
            o_locked       <= 1'b0;
            o_err          <= 1'b0;
            o_stall        <= 1'b0;
        end else begin
            r_state        <= state_nxt;
            r_count        <= count_nxt;
            r_good         <= good_nxt;
            o_period       <= period_nxt;
            o_period_valid <= valid_nxt;
            o_locked       <= locked_nxt;
            o_err          <= err_nxt;
            o_stall        <= stall_nxt;
        end
    end

    always_comb begin
        state_nxt = r_state;
        good_nxt  = r_good;
        count_nxt = r_count;
        if (e) begin
            count_nxt = '0;
            case (r_state)
                ST_IDLE: begin
                    state_nxt = ST_ACQ;
                    good_nxt  = '0;
                end
                ST_ACQ: begin
                    if (is_good(m)) begin
                        good_nxt = r_good + GW'(1);
                        if (r_good + GW'(1) == LOCK_G) state_nxt = ST_LOCKED;
                    end else begin
                        good_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!is_good(m)) begin
                        state_nxt = ST_ACQ;
                        good_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    good_nxt  = '0;
                end
            endcase
        end else begin
            if (r_count != W'(c_max)) count_nxt = r_count + W'(1);
            if (sat) begin
                state_nxt = ST_IDLE;
                good_nxt  = '0;
            end
        end
    end

    always_comb begin
        period_nxt = o_period;
        valid_nxt  = 1'b0;
        stall_nxt  = o_stall;
        locked_nxt = (state_nxt == ST_LOCKED);
        err_nxt    = (r_state == ST_LOCKED) && (state_nxt != ST_LOCKED);
        if (e) begin
            stall_nxt = 1'b0;
            if (r_state != ST_IDLE) begin
                period_nxt = m;
                valid_nxt  = 1'b1;
            end
        end else if (sat) begin
            stall_nxt = 1'b1;
        end
    end

endmodule
